// File: rtl/icache_rd_ctrl.sv
// icache_rd_ctrl: I-cache miss refill controller issuing one 4-beat AXI
// read burst per accepted miss and reporting completion/error status.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   miss_req/miss_addr  miss request and byte address (PC)
//   miss_ack            one-cycle pulse when a request is accepted
//   busy                high whenever the FSM is not IDLE
//   offset              word offset for the line return buffer
//   beat_cnt            count of accepted R beats (wraps 3->0)
//   refill_done/err     one-cycle completion pulse and its error flag
//   o_ar*/i_arready     AXI read-address channel
//   i_r*/o_rready       AXI read-data channel (rdata bypasses this block)
//   first_word_valid    pulse on the first accepted beat (CWF build only)
//
// Build option: ICACHE_CWF_EN selects critical-word-first (WRAP burst
// starting at the missed word) instead of an aligned INCR burst.

module icache_rd_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_req,
   input  logic [31:0] miss_addr,
   output logic        miss_ack,
   output logic        busy,
   output logic [1:0]  offset,
   output logic [1:0]  beat_cnt,
   output logic        refill_done,
   output logic        refill_err,
`ifdef ICACHE_CWF_EN
   output logic        first_word_valid,
`endif
   output logic [31:0] o_araddr,
   output logic [7:0]  o_arlen,
   output logic [2:0]  o_arsize,
   output logic [1:0]  o_arburst,
   output logic        o_arvalid,
   input  logic        i_arready,
   input  logic        i_rvalid,
   input  logic        i_rlast,
   input  logic [1:0]  i_rresp,
   output logic        o_rready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AR   = 2'd1,
      S_R    = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_araddr;
   logic        r_ack;
   logic        r_arvalid;
   logic        r_rready;
   logic [1:0]  r_beat_cnt;
   logic        r_err;
   logic        r_done;
   logic        r_rerr;

   logic        w_beat;
   logic        w_beat_err;
   logic        w_err_nxt;
   logic [31:0] w_araddr;
   logic        w_unused;

`ifdef ICACHE_CWF_EN
   logic        r_first;

   // WRAP burst starts at the missed word, data arrive pre-rotated
   assign w_araddr         = {miss_addr[31:2], 2'b00};
   assign o_arburst        = 2'b10;
   assign offset           = 2'b00;
   assign first_word_valid = r_first & w_beat;
`else
   logic [1:0]  r_offset;

   assign w_araddr  = {miss_addr[31:4], 4'h0};
   assign o_arburst = 2'b01;
   assign offset    = r_offset;
`endif

   // byte-lane bits never influence a word-granular line fill
   assign w_unused = ^miss_addr[1:0];

   assign o_arlen     = 8'd3;
   assign o_arsize    = 3'b010;
   assign o_araddr    = r_araddr;
   assign o_arvalid   = r_arvalid;
   assign o_rready    = r_rready;
   assign miss_ack    = r_ack;
   assign busy        = (r_state != S_IDLE);
   assign beat_cnt    = r_beat_cnt;
   assign refill_done = r_done;
   assign refill_err  = r_rerr;

   // A beat is bad on a non-OKAY response, on rlast before the 4th beat,
   // or when the 4th beat arrives without rlast (burst overrun).
   always_comb begin
      w_beat     = (r_state == S_R) & i_rvalid & r_rready;
      w_beat_err = (i_rresp != 2'b00)
                 | (i_rlast & (r_beat_cnt != 2'd3))
                 | (~i_rlast & (r_beat_cnt == 2'd3));
      w_err_nxt  = r_err | w_beat_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_araddr   <= 32'h0;
         r_ack      <= 1'b0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
         r_beat_cnt <= 2'd0;
         r_err      <= 1'b0;
         r_done     <= 1'b0;
         r_rerr     <= 1'b0;
`ifdef ICACHE_CWF_EN
         r_first    <= 1'b0;
`else
         r_offset   <= 2'd0;
`endif
      end else begin
         r_ack  <= 1'b0;
         r_done <= 1'b0;
         r_rerr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (miss_req) begin
                  r_araddr   <= w_araddr;
                  r_ack      <= 1'b1;
                  r_beat_cnt <= 2'd0;
                  r_err      <= 1'b0;
                  r_arvalid  <= 1'b1;
`ifndef ICACHE_CWF_EN
                  r_offset   <= miss_addr[3:2];
`endif
                  r_state    <= S_AR;
               end
            end
            S_AR: begin
               if (r_arvalid & i_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
`ifdef ICACHE_CWF_EN
                  r_first   <= 1'b1;
`endif
                  r_state   <= S_R;
               end
            end
            S_R: begin
               if (w_beat) begin
                  r_beat_cnt <= r_beat_cnt + 2'd1;
                  r_err      <= w_err_nxt;
`ifdef ICACHE_CWF_EN
                  r_first    <= 1'b0;
`endif
                  // rlast always closes the burst, early or not
                  if (i_rlast) begin
                     r_rready <= 1'b0;
                     r_done   <= 1'b1;
                     r_rerr   <= w_err_nxt;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
